// File: rtl/euclid_gcd_sequencer.sv
// Euclid GCD sequencer: drives an external modulo engine with (a, b), shifts (a, b) <= (b, a mod b)
// until b reaches zero, and reports the result, an iteration-bound error or an engine timeout.
module euclid_gcd_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_ITER = 32,
  parameter int unsigned WAIT_MAX = 1024
) (
  input  logic                            clk,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [WIDTH-1:0]                a_i,
  input  logic [WIDTH-1:0]                b_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [1:0]                      err_code_o,
  output logic [WIDTH-1:0]                gcd_o,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_o,
  output logic                            mod_start_o,
  output logic [WIDTH-1:0]                mod_a_o,
  output logic [WIDTH-1:0]                mod_b_o,
  input  logic                            mod_valid_i,
  input  logic [WIDTH-1:0]                mod_rem_i
);

  localparam int unsigned IterW = $clog2(MAX_ITER + 1);
  localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [IterW-1:0] IterLast = IterW'(MAX_ITER);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrZero    = 2'd1;
  localparam logic [1:0] ErrIter    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StStartMod,
    StWaitMod,
    StUpdate,
    StDone,
    StError
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WaitW-1:0]   wait_cnt_q;
  logic [IterW-1:0]   iter_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [1:0]         err_code_q;
  logic [WIDTH-1:0]   gcd_q;
  logic               mod_start_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      wait_cnt_q  <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
      gcd_q       <= '0;
      mod_start_q <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised only on the transition into its state.
      done_q      <= 1'b0;
      mod_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StLoad;
            a_q        <= a_i;
            b_q        <= b_i;
            iter_q     <= '0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            gcd_q      <= '0;
          end
        end
        StLoad: begin
          state_q <= StCheck;
        end
        StCheck: begin
          if (a_q == '0 && b_q == '0) begin
            state_q    <= StError;
            err_q      <= 1'b1;
            err_code_q <= ErrZero;
            gcd_q      <= '0;
            done_q     <= 1'b1;
          end else if (b_q == '0) begin
            state_q <= StDone;
            gcd_q   <= a_q;
            done_q  <= 1'b1;
          end else if (a_q == '0) begin
            state_q <= StDone;
            gcd_q   <= b_q;
            done_q  <= 1'b1;
          end else begin
            state_q     <= StStartMod;
            mod_start_q <= 1'b1;
          end
        end
        StStartMod: begin
          state_q    <= StWaitMod;
          iter_q     <= iter_q + 1'b1;
          wait_cnt_q <= '0;
        end
        StWaitMod: begin
          // A valid arriving on the final allowed cycle still counts as a result.
          if (mod_valid_i) begin
            state_q <= StUpdate;
            rem_q   <= mod_rem_i;
          end else if (wait_cnt_q == WaitLast) begin
            state_q    <= StError;
            err_q      <= 1'b1;
            err_code_q <= ErrTimeout;
            gcd_q      <= '0;
            done_q     <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StUpdate: begin
          a_q <= b_q;
          b_q <= rem_q;
          // A zero remainder on the last allowed call finishes normally via CHECK.
          if (iter_q == IterLast && rem_q != '0) begin
            state_q    <= StError;
            err_q      <= 1'b1;
            err_code_q <= ErrIter;
            gcd_q      <= '0;
            done_q     <= 1'b1;
          end else begin
            state_q <= StCheck;
          end
        end
        StDone, StError: begin
          // Clearing the operands keeps mod_a_o/mod_b_o at zero while idle.
          state_q <= StIdle;
          busy_q  <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign gcd_o       = gcd_q;
  assign iter_o      = iter_q;
  assign mod_start_o = mod_start_q;
  assign mod_a_o     = a_q;
  assign mod_b_o     = b_q;

endmodule

// File: tb/tb_euclid_gcd_sequencer.sv
// Self-checking bench for euclid_gcd_sequencer with a behavioural modulo engine of programmable
// latency; directed vector table plus reset and back-to-back sequences.
module tb_euclid_gcd_sequencer;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned MAX_ITER = 4;
  localparam int unsigned WAIT_MAX = 8;
  localparam int unsigned IW       = $clog2(MAX_ITER + 1);

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [1:0]       err_code_o;
  logic [WIDTH-1:0] gcd_o;
  logic [IW-1:0]    iter_o;
  logic             mod_start_o;
  logic [WIDTH-1:0] mod_a_o;
  logic [WIDTH-1:0] mod_b_o;
  logic             mod_valid_i = 1'b0;
  logic [WIDTH-1:0] mod_rem_i = '0;

  always #5 clk = ~clk;

  euclid_gcd_sequencer #(
    .WIDTH    (WIDTH),
    .MAX_ITER (MAX_ITER),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .gcd_o       (gcd_o),
    .iter_o      (iter_o),
    .mod_start_o (mod_start_o),
    .mod_a_o     (mod_a_o),
    .mod_b_o     (mod_b_o),
    .mod_valid_i (mod_valid_i),
    .mod_rem_i   (mod_rem_i)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               w;      // engine latency in WAIT_MOD cycles, 0 = never answers
    logic [WIDTH-1:0] gcd;
    logic             err;
    logic [1:0]       code;
    int               iter;
    int               pulses;
    int               cyc;    // cycle of done_o counted from the start-sampling edge
  } vec_t;

  vec_t vecs[12];

  int checks = 0;
  int errors = 0;

  // Engine model state: expected operands follow Euclid independently of the DUT.
  int               eng_w = 1;
  bit               eng_busy = 1'b0;
  int               eng_cnt = 0;
  bit               spur = 1'b0;
  int               pulses = 0;
  logic [WIDTH-1:0] ma = '0;
  logic [WIDTH-1:0] mb = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    mod_valid_i = 1'b0;
    mod_rem_i   = '0;
    if (mod_start_o) begin
      pulses++;
      chk("mod_ops", {mod_a_o, mod_b_o}, {ma, mb});
      eng_busy = 1'b1;
      eng_cnt  = 0;
    end else if (eng_busy) begin
      eng_cnt++;
      if (eng_w != 0 && eng_cnt == eng_w) begin
        chk("mod_hold", {mod_a_o, mod_b_o}, {ma, mb});
        mod_valid_i = 1'b1;
        mod_rem_i   = (mb == '0) ? '0 : ma % mb;
        ma          = mb;
        mb          = mod_rem_i;
        eng_busy    = 1'b0;
      end
    end else if (spur) begin
      mod_valid_i = 1'b1;
      mod_rem_i   = 16'hdead;
    end
  endtask

  task automatic run_job(input vec_t v, input bit hold);
    int n;
    bit seen;
    for (int i = 0; i < 50 && busy_o; i++) step();
    chk("idle_before_start", busy_o, 0);
    eng_w    = v.w;
    eng_busy = 1'b0;
    ma       = v.a;
    mb       = v.b;
    pulses   = 0;
    start_i  = 1'b1;
    a_i      = v.a;
    b_i      = v.b;
    n        = 0;
    seen     = 1'b0;
    while (!seen && n < 200) begin
      step();
      n++;
      start_i = hold;
      if (done_o) begin
        seen = 1'b1;
        chk("done_cycle", n, v.cyc);
        chk("gcd", gcd_o, v.gcd);
        chk("err", err_o, v.err);
        chk("err_code", err_code_o, v.code);
        chk("iter", iter_o, v.iter);
        chk("mod_pulses", pulses, v.pulses);
      end
    end
    chk("done_seen", seen, 1);
    step();
    chk("done_one_cycle", done_o, 0);
    chk("idle_after_done", busy_o, 0);
    chk("gcd_held", gcd_o, v.gcd);
    chk("err_held", {err_o, err_code_o}, {v.err, v.code});
  endtask

  initial begin
    int n;
    bit seen;
    vec_t v;
    //          a       b        w  gcd     err   code  iter pls cyc
    vecs[0]  = '{16'd48, 16'd18,    2, 16'd6,  1'b0, 2'd0, 3, 3, 18};
    vecs[1]  = '{16'd0,  16'd7,     1, 16'd7,  1'b0, 2'd0, 0, 0, 3};
    vecs[2]  = '{16'd9,  16'd0,     1, 16'd9,  1'b0, 2'd0, 0, 0, 3};
    vecs[3]  = '{16'd0,  16'd0,     1, 16'd0,  1'b1, 2'd1, 0, 0, 3};
    vecs[4]  = '{16'd89, 16'd55,    1, 16'd0,  1'b1, 2'd2, 4, 4, 18};
    vecs[5]  = '{16'd8,  16'd5,     1, 16'd1,  1'b0, 2'd0, 4, 4, 19};
    vecs[6]  = '{16'd25, 16'd25,    3, 16'd25, 1'b0, 2'd0, 1, 1, 9};
    vecs[7]  = '{16'd18, 16'd48,    2, 16'd6,  1'b0, 2'd0, 4, 4, 23};
    vecs[8]  = '{16'd12, 16'd8,     8, 16'd4,  1'b0, 2'd0, 2, 2, 25};
    vecs[9]  = '{16'd12, 16'd8,     0, 16'd0,  1'b1, 2'd3, 1, 1, 12};
    vecs[10] = '{16'd1,  16'd65535, 1, 16'd1,  1'b0, 2'd0, 2, 2, 11};
    vecs[11] = '{16'd13, 16'd8,     1, 16'd0,  1'b1, 2'd2, 4, 4, 18};

    // Reset state
    @(negedge clk);
    chk("reset_outs", {busy_o, done_o, err_o, err_code_o, gcd_o, iter_o, mod_start_o},
        64'd0);
    chk("reset_mod_ops", {mod_a_o, mod_b_o}, 64'd0);
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_job(vecs[i], 1'b0);

    // Asynchronous reset in the middle of WAIT_MOD
    eng_w    = 0;
    eng_busy = 1'b0;
    ma       = 16'd12;
    mb       = 16'd8;
    pulses   = 0;
    start_i  = 1'b1;
    a_i      = 16'd12;
    b_i      = 16'd8;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_busy", {busy_o, mod_a_o, mod_b_o}, {1'b1, 16'd12, 16'd8});
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_outs", {busy_o, done_o, err_o, err_code_o, gcd_o, iter_o, mod_start_o},
        64'd0);
    chk("rst_async_mod_ops", {mod_a_o, mod_b_o}, 64'd0);
    @(negedge clk);
    rst_i    = 1'b0;
    eng_busy = 1'b0;
    v = '{16'd12, 16'd8, 2, 16'd4, 1'b0, 2'd0, 2, 2, 13};
    run_job(v, 1'b0);

    // start_i held high with spurious valids outside WAIT_MOD
    spur = 1'b1;
    run_job(vecs[0], 1'b1);
    ma       = 16'd48;
    mb       = 16'd18;
    eng_w    = 2;
    eng_busy = 1'b0;
    pulses   = 0;
    step();
    chk("b2b_restart", busy_o, 1);
    start_i = 1'b0;
    spur    = 1'b0;
    n       = 0;
    seen    = 1'b0;
    while (!seen && n < 200) begin
      step();
      n++;
      if (done_o) begin
        seen = 1'b1;
        chk("b2b_gcd", {err_o, gcd_o}, {1'b0, 16'd6});
        chk("b2b_cycle", n, 17);
      end
    end
    chk("b2b_done_seen", seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
